// File: rtl/cpu_seq_pkg.sv
// Shared types and widths for the instruction sequencer.
package cpu_seq_pkg;
    localparam int FUNC_W = 7;
    localparam int RET_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/seq_fifo.sv
// Small power-of-two FIFO with synchronous flush.
module seq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 7,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      lvl_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (lvl_q == (AW+1)'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;
    assign dout_o  = mem[rd_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   lvl_q <= lvl_q + 1'b1;
                2'b01:   lvl_q <= lvl_q - 1'b1;
                default: lvl_q <= lvl_q;
            endcase
        end
    end
endmodule

// File: rtl/cpu_instr_sequencer.sv
// Queues FUNCTION words and issues them one at a time to the
// control unit, waiting for Finish with a bounded timeout.
module cpu_instr_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 15,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [FUNC_W-1:0] instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              flush,
    output logic [FUNC_W-1:0] FUNCTION,
    output logic              W,
    input  logic              Finish,
    output logic              busy,
    output logic              timeout_err,
    output logic [RET_W-1:0]  retired_count,
    output logic [LW-1:0]     fifo_level
);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic              w_q, w_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic              terr_q, terr_d;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FUNC_W-1:0] head;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FUNC_W)
    ) u_fifo (
        .clk_i   (clk),
        .clr_i   (clr),
        .push_i  (instr_valid),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (instr_in),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign instr_ready   = !full && !flush;
    assign busy          = (state_q != IDLE) || !empty;
    assign FUNCTION      = func_q;
    assign W             = w_q;
    assign timeout_err   = terr_q;
    assign retired_count = ret_q;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        w_d     = 1'b0;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        terr_d  = flush ? 1'b0 : terr_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !flush) begin
                    pop     = 1'b1;
                    func_d  = head;
                    w_d     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Finish beats a timeout landing on the same edge
                if (Finish) begin
                    ret_d   = ret_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIM) begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            func_q  <= '0;
            w_q     <= 1'b0;
            cnt_q   <= '0;
            ret_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Directed bench for cpu_instr_sequencer (DEPTH=4, TIMEOUT=15).
module tb_cpu_instr_sequencer;
    logic       clk;
    logic       clr;
    logic [6:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic       flush;
    logic [6:0] FUNCTION;
    logic       W;
    logic       Finish;
    logic       busy;
    logic       timeout_err;
    logic [7:0] retired_count;
    logic [2:0] fifo_level;

    int nvec;
    int nerr;

    cpu_instr_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .instr_in      (instr_in),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .flush         (flush),
        .FUNCTION      (FUNCTION),
        .W             (W),
        .Finish        (Finish),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .retired_count (retired_count),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        clr = 1'b1;
        instr_in = '0;
        instr_valid = 1'b0;
        flush = 1'b0;
        Finish = 1'b0;
        #2;
        check("rst_func", FUNCTION, 0);
        check("rst_w", W, 0);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_ret", retired_count, 0);
        check("rst_lvl", fifo_level, 0);
        tick();
        clr = 1'b0;
        tick();

        // single word issue and Finish
        instr_in = 7'h15;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t1_lvl_push", fifo_level, 1);
        check("t1_busy", busy, 1);
        check("t1_w_pre", W, 0);
        tick();
        check("t1_w_issue", W, 1);
        check("t1_func", FUNCTION, 7'h15);
        check("t1_lvl_pop", fifo_level, 0);
        tick();
        check("t1_w_wait", W, 0);
        check("t1_func_hold", FUNCTION, 7'h15);
        tick();
        tick();
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        check("t1_ret", retired_count, 1);
        check("t1_busy_done", busy, 0);

        // fill the FIFO while stalled in WAIT
        instr_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            instr_in = 7'(i);
            tick();
        end
        instr_in = 7'h06;
        check("t2_lvl_full", fifo_level, 4);
        check("t2_ready_full", instr_ready, 0);
        check("t2_func", FUNCTION, 7'h01);
        tick();
        check("t2_lvl_held", fifo_level, 4);
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        check("t2_ret", retired_count, 2);
        check("t2_ready_still", instr_ready, 0);
        tick();
        check("t2_w_issue", W, 1);
        check("t2_func2", FUNCTION, 7'h02);
        check("t2_lvl_pop", fifo_level, 3);
        check("t2_ready_open", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check("t2_lvl_refill", fifo_level, 4);
        check("t2_w_off", W, 0);

        // Finish on the timeout edge
        repeat (14) tick();
        check("t4_terr_pre", timeout_err, 0);
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        check("t4_ret", retired_count, 3);
        check("t4_terr", timeout_err, 0);
        tick();
        check("t4_w_next", W, 1);
        check("t4_func_next", FUNCTION, 7'h03);
        check("t4_lvl", fifo_level, 3);

        // genuine timeout
        tick();
        repeat (14) tick();
        check("t3_terr_pre", timeout_err, 0);
        check("t3_busy", busy, 1);
        tick();
        check("t3_terr", timeout_err, 1);
        check("t3_ret", retired_count, 3);
        check("t3_w", W, 0);
        tick();
        check("t3_w_next", W, 1);
        check("t3_func_next", FUNCTION, 7'h04);
        check("t3_lvl", fifo_level, 2);

        // flush with 3 queued while in WAIT
        instr_in = 7'h07;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t5_lvl_pre", fifo_level, 3);
        flush = 1'b1;
        #1;
        check("t5_ready_flush", instr_ready, 0);
        tick();
        flush = 1'b0;
        check("t5_lvl", fifo_level, 0);
        check("t5_terr_clr", timeout_err, 0);
        check("t5_busy", busy, 1);
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        check("t5_ret", retired_count, 4);
        check("t5_busy_done", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_w", W, 0);
        end
        check("t5_func", FUNCTION, 7'h04);

        // clr during ISSUE
        instr_in = 7'h2A;
        instr_valid = 1'b1;
        tick();
        instr_in = 7'h2B;
        tick();
        instr_valid = 1'b0;
        check("t6_w_issue", W, 1);
        check("t6_lvl", fifo_level, 1);
        #1;
        clr = 1'b1;
        #1;
        check("t6_w_async", W, 0);
        check("t6_func", FUNCTION, 0);
        check("t6_ready", instr_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_ret", retired_count, 0);
        check("t6_lvl_clr", fifo_level, 0);
        tick();
        clr = 1'b0;
        tick();

        // retired_count wrap
        for (int i = 0; i < 255; i++) begin
            instr_in = 7'(i);
            instr_valid = 1'b1;
            tick();
            instr_valid = 1'b0;
            tick();
            tick();
            Finish = 1'b1;
            tick();
            Finish = 1'b0;
        end
        check("t6_ret_255", retired_count, 255);
        check("t6_func_last", FUNCTION, 7'h7E);
        instr_in = 7'h55;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        check("t6_ret_wrap", retired_count, 0);
        check("t6_func_wrap", FUNCTION, 7'h55);
        check("t6_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cpu_instr_sequencer.md
# cpu_instr_sequencer

Front-end sequencer that feeds the 8-bit processor's control unit. It buffers 7-bit FUNCTION words from a host in a small FIFO and issues them one at a time as FUNCTION plus a one-cycle W strobe. It waits for the control unit's Finish before issuing the next word, and flags a timeout if Finish never arrives. It sits between the host/test harness and the processor, owning the FUNCTION/W inputs and consuming Finish.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TIMEOUT, 15, max WAIT cycles before abandoning an instruction (1..255)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-high reset
- instr_in  in  7  FUNCTION word from host
- instr_valid  in  1  host offers instr_in
- instr_ready  out  1  sequencer accepts; = !full && !flush
- flush  in  1  discard all queued (not in-flight) words
- FUNCTION  out  7  word presented to control unit
- W  out  1  one-cycle start strobe to control unit
- Finish  in  1  control unit completion
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- timeout_err  out  1  sticky: an instruction timed out
- retired_count  out  8  instructions completed with Finish, wraps
- fifo_level  out  clog2(DEPTH)+1  occupied entries

## Operation
- Reset values: FUNCTION=0, W=0, instr_ready=1, busy=0, timeout_err=0, retired_count=0, fifo_level=0, state=IDLE.
- Push: instr_valid && instr_ready at a rising edge writes instr_in at the tail. No bypass; full ⇒ instr_ready=0.
- The FSM has three states.
- IDLE: if FIFO non-empty, pop head into the FUNCTION register and go to ISSUE. Otherwise stay.
- ISSUE: W=1 for exactly this one cycle. Timeout counter cleared. Next state is WAIT unconditionally. Finish is ignored in ISSUE.
- WAIT: W=0. FUNCTION is held stable.
  - Finish=1 ⇒ retired_count+1 (mod 256), then IDLE.
  - Otherwise the counter increments. If it reaches TIMEOUT ⇒ timeout_err=1, then IDLE, with no count increment.
  - Finish and timeout on the same edge ⇒ Finish wins.
- FUNCTION keeps its last issued value in IDLE until the next pop.
- A pop and a push on the same edge are legal. Level is unchanged.
- Flush: at the edge it is sampled, head/tail/level are reset to 0 and timeout_err is cleared. An in-flight instruction (ISSUE/WAIT) completes normally. A push in the same cycle is not accepted (instr_ready=0). A pop in the same cycle is suppressed: IDLE stays IDLE.
- clr mid-operation: all state returns to reset values immediately (W drops asynchronously). Queued words are lost.

## Timing
- Push at edge t, FIFO previously empty, FSM in IDLE:
  - edge t+1: pop, state=ISSUE, W=1 in cycle (t+1, t+2).
  - edge t+2: state=WAIT.
- Finish high when sampled at edge f ⇒ IDLE after f.
  - If the FIFO is non-empty, the next pop is at f+1 and the next W is in cycle (f+1, f+2).
  - Minimum issue spacing is therefore 3 cycles.
- Timeout: with no Finish, timeout_err rises after edge t+2+TIMEOUT. The FSM is back in IDLE at that edge.
- All outputs are registered except instr_ready and busy, which are combinational from registered state plus flush.

## Structure
- Shared package cpu_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the FUNCTION width constant (7);
  - the retired_count width constant (8).
- Sub-module seq_fifo implements the FIFO:
  - parameters DEPTH and width;
  - push, pop, flush;
  - dout, full, empty, level.
- The FSM and counters live in cpu_instr_sequencer.

## Test plan
- Reset then single push of 7'h15 ⇒ W high exactly one cycle, FUNCTION=7'h15 two edges after push. Finish pulsed 3 cycles later ⇒ retired_count=1, busy=0.
- Push 5 words back-to-back with DEPTH=4 and the FSM stalled in WAIT ⇒ instr_ready drops when fifo_level=4. The 5th word is held by the host and accepted after the first pop.
- Finish never asserted, TIMEOUT=15 ⇒ timeout_err=1 after exactly 15 WAIT cycles, retired_count unchanged, next queued word issues.
- Finish asserted on the same edge the counter reaches TIMEOUT ⇒ retired_count increments, timeout_err stays 0.
- Flush while in WAIT with 3 queued ⇒ fifo_level=0, in-flight word completes on Finish, no further W.
- clr asserted during ISSUE ⇒ W=0 immediately and every output at its reset value. After release, retired_count=255 plus one Finish wraps to 0.
